// File: rtl/data_mem_resp_pkg.sv
// Shared constants and lane helpers for the data-memory responder.
// Used by the RTL and by the bench.
package data_mem_resp_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] DM_IDLE  = 3'd0;
   localparam logic [2:0] DM_RD    = 3'd1;
   localparam logic [2:0] DM_MERGE = 3'd2;
   localparam logic [2:0] DM_WR    = 3'd3;
   localparam logic [2:0] DM_RESP  = 3'd4;

   function automatic logic f3_legal(input logic [2:0] f3, input logic store);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] low);
      return (((f3 == F3_H) || (f3 == F3_HU)) && low[0]) ||
             ((f3 == F3_W) && (low != 2'b00));
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    res = {{24{b[7]}}, b};
         F3_BU:   res = {24'd0, b};
         F3_H:    res = {{16{h[15]}}, h};
         F3_HU:   res = {16'd0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
      logic [31:0] res;
      res = old;
      case (f3)
         F3_B: begin
            case (lane)
               2'd0:    res[7:0]   = wd[7:0];
               2'd1:    res[15:8]  = wd[7:0];
               2'd2:    res[23:16] = wd[7:0];
               default: res[31:24] = wd[7:0];
            endcase
         end
         F3_H: begin
            if (lane[1]) res[31:16] = wd[15:0];
            else         res[15:0]  = wd[15:0];
         end
         default: res = wd;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Load/store request bus between the core and the data-memory responder.
interface data_mem_resp_if;
   // Handshake: the master raises lw_en or sw_en with addr/wdata/funct3 and holds
   // them until ready; the slave captures them on the accepting edge (only while
   // busy=0), ignores the inputs while busy, and pulses ready (with err on a
   // rejected request) for exactly one cycle; busy falls the cycle after ready.
   logic        lw_en;
   logic        sw_en;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (output lw_en, sw_en, funct3, addr, wdata,
                   input  rdata, ready, err, busy);
   modport slave  (input  lw_en, sw_en, funct3, addr, wdata,
                   output rdata, ready, err, busy);
endinterface

// File: rtl/data_mem_resp_dmem_array.sv
// Single-port synchronous data RAM, 2**ADDR_W words of 32 bits, read-first.
module dmem_array #(
   parameter int    ADDR_W    = 10,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       din,
   output logic [31:0]       dout
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= din;
      dout <= mem[waddr];
   end

endmodule

// File: rtl/data_mem_resp.sv
// Load/store responder: checks, read-modify-write for sub-word stores and
// load extension around a synchronous data RAM.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int    ADDR_W    = 10,
   parameter string INIT_FILE = ""
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_resp_if.slave       bus,
   output logic [2:0]           dbg_state
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] widx_q;
   logic [1:0]        lane_q;
   logic [2:0]        f3_q;
   logic              store_q;
   logic              err_q;
   logic [31:0]       wdata_q;
   logic [31:0]       wbuf_q;
   logic [31:0]       rdata_q;
   logic [31:0]       dout;
   logic [ADDR_W-1:0] ram_addr;
   logic              we;
   logic              req;
   logic              bad;

   assign req = bus.lw_en | bus.sw_en;

   always_comb begin
      bad = 1'b0;
      if (bus.lw_en && bus.sw_en)                    bad = 1'b1;
      if (!f3_legal(bus.funct3, bus.sw_en))          bad = 1'b1;
      if (misaligned(bus.funct3, bus.addr[1:0]))     bad = 1'b1;
      if ((bus.addr >> (ADDR_W + 2)) != 32'd0)       bad = 1'b1;
   end

   // In IDLE the RAM is addressed straight from the bus so the read data is
   // already waiting when the FSM reaches RD.
   assign ram_addr = (state == DM_IDLE) ? bus.addr[ADDR_W+1:2] : widx_q;
   // A reset on the same edge as the WR commit suppresses the write.
   assign we       = (state == DM_WR) && !rst;

   dmem_array #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (ram_addr),
      .din   (wbuf_q),
      .dout  (dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DM_IDLE;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         widx_q  <= '0;
         lane_q  <= 2'd0;
         f3_q    <= 3'd0;
         store_q <= 1'b0;
         wdata_q <= 32'd0;
         wbuf_q  <= 32'd0;
      end else begin
         case (state)
            DM_IDLE: begin
               if (req) begin
                  widx_q  <= bus.addr[ADDR_W+1:2];
                  lane_q  <= bus.addr[1:0];
                  f3_q    <= bus.funct3;
                  store_q <= bus.sw_en;
                  wdata_q <= bus.wdata;
                  wbuf_q  <= bus.wdata;
                  err_q   <= bad;
                  if (bad)                                  state <= DM_RESP;
                  else if (bus.sw_en && bus.funct3 == F3_W) state <= DM_WR;
                  else                                      state <= DM_RD;
               end
            end
            DM_RD: begin
               if (store_q) begin
                  wbuf_q <= store_merge(dout, wdata_q, f3_q, lane_q);
                  state  <= DM_MERGE;
               end else begin
                  rdata_q <= load_extend(dout, f3_q, lane_q);
                  state   <= DM_RESP;
               end
            end
            DM_MERGE: state <= DM_WR;
            DM_WR:    state <= DM_RESP;
            DM_RESP:  state <= DM_IDLE;
            default:  state <= DM_IDLE;
         endcase
      end
   end

   assign bus.ready = (state == DM_RESP);
   assign bus.err   = (state == DM_RESP) && err_q;
   assign bus.busy  = (state != DM_IDLE);
   assign bus.rdata = rdata_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized bench for data_mem_resp against a byte-lane memory model, plus
// directed literal checks for stores, loads, errors, reset and back-to-back.
module tb_data_mem_resp;
   import data_mem_resp_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  dbg_state;

   data_mem_resp_if bus();

   data_mem_resp #(.ADDR_W(10), .INIT_FILE("")) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          ncyc = 0;
   int          busy_from = 0;
   int          busy_until = -1;
   int          acc_n = 0;
   int          last_ready_n = 0;
   logic        last_err_seen = 1'b0;
   logic        rst_at_edge = 1'b1;
   logic [31:0] rdata_hold = 32'd0;
   logic [31:0] mem_m [0:1023];

   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   logic        exp_err_q[$];
   logic        exp_ld_q[$];

   logic [2:0]  f3_list [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
      end
   endtask

   // Model: what a request must do, from the load/store rules alone.
   function automatic void model_op(input logic lw, input logic sw, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic e, output int lat, output logic [31:0] rd);
      logic [31:0] w, v, mask;
      int sh;
      e  = 1'b0;
      rd = 32'd0;
      if (lw && sw) e = 1'b1;
      if (!((f3 inside {3'd0, 3'd1, 3'd2}) || ((f3 inside {3'd4, 3'd5}) && !sw))) e = 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e = 1'b1;
      if (f3 == 3'd2 && a[1:0] != 2'd0) e = 1'b1;
      if (a >= 32'h1000) e = 1'b1;
      if (e)              lat = 1;
      else if (lw)        lat = 2;
      else if (f3 == 3'd2) lat = 2;
      else                lat = 4;
      if (!e) begin
         w  = mem_m[a[11:2]];
         sh = 8 * int'(a[1:0]);
         if (f3 == 3'd1 || f3 == 3'd5) sh = 16 * int'(a[1]);
         if (lw) begin
            v = w >> sh;
            case (f3)
               3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
               3'd4: v = v & 32'hFF;
               3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
               3'd5: v = v & 32'hFFFF;
               default: v = w;
            endcase
            rd = v;
         end else begin
            if (f3 == 3'd0)      mask = 32'hFF << sh;
            else if (f3 == 3'd1) mask = 32'hFFFF << sh;
            else                 mask = 32'hFFFF_FFFF;
            mem_m[a[11:2]] = (w & ~mask) | ((wd << sh) & mask);
         end
      end
   endfunction

   always @(posedge clk) rst_at_edge <= rst;

   // Compare process: every cycle, against the model's expected responses.
   always @(negedge clk) begin
      logic exp_rdy;
      ncyc++;
      if (rst_at_edge) begin
         exp_q.delete(); exp_cyc_q.delete(); exp_err_q.delete(); exp_ld_q.delete();
         busy_from  = 0;
         busy_until = -1;
         rdata_hold = 32'd0;
         chk("reset ready", 32'(bus.ready), 32'd0);
         chk("reset err",   32'(bus.err),   32'd0);
         chk("reset busy",  32'(bus.busy),  32'd0);
         chk("reset rdata", bus.rdata,      32'd0);
      end else begin
         exp_rdy = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == ncyc);
         chk("ready", 32'(bus.ready), 32'(exp_rdy));
         if (exp_rdy) begin
            chk("err", 32'(bus.err), 32'(exp_err_q[0]));
            if (!exp_err_q[0] && exp_ld_q[0]) rdata_hold = exp_q[0];
            last_err_seen = bus.err;
            last_ready_n  = ncyc;
            void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front());
            void'(exp_err_q.pop_front()); void'(exp_ld_q.pop_front());
         end
         chk("busy",  32'(bus.busy), 32'((ncyc >= busy_from) && (ncyc <= busy_until)));
         chk("rdata", bus.rdata, rdata_hold);
      end
   end

   task automatic scramble();
      bus.lw_en  = 1'($urandom_range(0, 1));
      bus.sw_en  = 1'($urandom_range(0, 1));
      bus.funct3 = 3'($urandom_range(0, 7));
      bus.addr   = $urandom;
      bus.wdata  = $urandom;
   endtask

   task automatic issue(input logic lw, input logic sw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit garbage);
      logic e;
      int lat;
      logic [31:0] rd;
      int n;
      model_op(lw, sw, f3, a, wd, e, lat, rd);
      @(posedge clk); #1;
      bus.lw_en = lw; bus.sw_en = sw; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
      n = ncyc;
      acc_n = n;
      exp_cyc_q.push_back(n + 1 + lat);
      exp_err_q.push_back(e);
      exp_ld_q.push_back(lw && !sw);
      exp_q.push_back(rd);
      busy_from  = n + 2;
      busy_until = n + 1 + lat;
      @(posedge clk); #1;
      if (garbage) scramble();
      for (int i = 1; i < lat; i++) begin
         @(posedge clk); #1;
         if (garbage) scramble();
      end
      bus.lw_en = 1'b0;
      bus.sw_en = 1'b0;
   endtask

   task automatic op(input string name, input logic lw, input logic sw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int want_lat,
                     input logic want_err, input bit chk_rd, input logic [31:0] want_rd);
      issue(lw, sw, f3, a, wd, 1'b1);
      @(posedge clk); #1;
      chk({name, " latency"}, 32'(last_ready_n - acc_n - 1), 32'(want_lat));
      chk({name, " err"}, 32'(last_err_seen), 32'(want_err));
      if (chk_rd) chk({name, " rdata"}, bus.rdata, want_rd);
   endtask

   initial begin
      int k;
      logic lw, sw;
      logic [2:0] f3;
      logic [31:0] a;
      bus.lw_en = 1'b0; bus.sw_en = 1'b0; bus.funct3 = 3'd0;
      bus.addr = 32'd0; bus.wdata = 32'd0;
      for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("state after reset", 32'(dbg_state), 32'(DM_IDLE));

      for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, F3_W, 32'(i * 4), $urandom, 1'b1);

      op("sw 0x10",  0, 1, F3_W,  32'h10, 32'hDEADBEEF, 2, 0, 0, 32'd0);
      op("lw 0x10",  1, 0, F3_W,  32'h10, 32'd0,        2, 0, 1, 32'hDEADBEEF);
      op("sb 0x11",  0, 1, F3_B,  32'h11, 32'h000000A5, 4, 0, 0, 32'd0);
      op("lw merged", 1, 0, F3_W, 32'h10, 32'd0,        2, 0, 1, 32'hDEADA5EF);
      op("lb 0x11",  1, 0, F3_B,  32'h11, 32'd0,        2, 0, 1, 32'hFFFFFFA5);
      op("lbu 0x11", 1, 0, F3_BU, 32'h11, 32'd0,        2, 0, 1, 32'h000000A5);
      op("sh 0x12",  0, 1, F3_H,  32'h12, 32'h00008001, 4, 0, 0, 32'd0);
      op("lh 0x12",  1, 0, F3_H,  32'h12, 32'd0,        2, 0, 1, 32'hFFFF8001);
      op("lhu 0x12", 1, 0, F3_HU, 32'h12, 32'd0,        2, 0, 1, 32'h00008001);

      op("lw misaligned", 1, 0, F3_W,  32'h13,   32'd0,        1, 1, 0, 32'd0);
      op("sh misaligned", 0, 1, F3_H,  32'h11,   32'h1234,     1, 1, 0, 32'd0);
      op("both enables",  1, 1, F3_W,  32'h10,   32'h0,        1, 1, 0, 32'd0);
      op("lw range",      1, 0, F3_W,  32'h1000, 32'd0,        1, 1, 0, 32'd0);
      op("sb range",      0, 1, F3_B,  32'h1001, 32'h55,       1, 1, 0, 32'd0);
      op("sbu store",     0, 1, F3_BU, 32'h10,   32'h77,       1, 1, 0, 32'd0);
      op("funct3 011",    1, 0, 3'b011, 32'h10,  32'd0,        1, 1, 0, 32'd0);
      op("lw unchanged",  1, 0, F3_W,  32'h10,   32'd0,        2, 0, 1, 32'h8001A5EF);

      // Reset during the merge step of a byte store must leave the word alone.
      op("sw 0x20", 0, 1, F3_W, 32'h20, 32'h12345678, 2, 0, 0, 32'd0);
      @(posedge clk); #1;
      bus.lw_en = 1'b0; bus.sw_en = 1'b1; bus.funct3 = F3_B;
      bus.addr = 32'h20; bus.wdata = 32'h5A;
      k = ncyc;
      exp_cyc_q.push_back(k + 5); exp_err_q.push_back(1'b0);
      exp_ld_q.push_back(1'b0);   exp_q.push_back(32'd0);
      busy_from = k + 2; busy_until = k + 5;
      @(posedge clk); #1;
      bus.sw_en = 1'b0;
      @(posedge clk); #1;
      chk("state in merge", 32'(dbg_state), 32'(DM_MERGE));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("state after mid-op reset", 32'(dbg_state), 32'(DM_IDLE));
      repeat (6) @(posedge clk);
      op("lw 0x20 kept", 1, 0, F3_W, 32'h20, 32'd0, 2, 0, 1, 32'h12345678);

      // Requests held through busy, issued back to back.
      issue(1'b1, 1'b0, F3_W, 32'h10, 32'd0, 1'b0);
      issue(1'b0, 1'b1, F3_B, 32'h13, 32'hC3, 1'b0);
      issue(1'b1, 1'b0, F3_B, 32'h13, 32'd0, 1'b0);
      issue(1'b1, 1'b0, F3_W, 32'h10, 32'd0, 1'b0);
      @(posedge clk); #1;
      chk("held sb result", bus.rdata, 32'hC301A5EF);

      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 19);
         lw = (k == 0) || (k < 10);
         sw = (k == 0) || (k >= 10);
         if ($urandom_range(0, 9) < 8) f3 = f3_list[$urandom_range(0, 4)];
         else                          f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 24) == 0) a = $urandom | 32'h1000;
         else                            a = 32'($urandom_range(0, 63));
         issue(lw, sw, f3, a, $urandom, 1'($urandom_range(0, 1)));
      end

      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
